// File: rtl/chain_seq_pkg.sv
// chain_seq_pkg
//   Shared definitions for the chain sequencer:
//   - state_t      : sequencer FSM states
//   - STAT_W       : width of the frame/error statistics counters
//   - MAX_STAGES   : upper bound on NUM_STAGES, fixes the search width
//   - next_enabled : finds the lowest non-bypassed stage at or above an index
package chain_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LAUNCH  = 3'd1,
    S_WAIT    = 3'd2,
    S_ADVANCE = 3'd3,
    S_FINISH  = 3'd4,
    S_ERROR   = 3'd5
  } state_t;

  localparam int STAT_W     = 16;
  localparam int MAX_STAGES = 16;

  typedef struct packed {
    logic       valid;
    logic [3:0] idx;
  } search_t;

  // Lowest index i >= from with bypass[i]==0. Callers pad unused upper
  // stages with 1 so they are never selected. 'from' is one bit wider
  // than an index so that "search past the last stage" can be expressed.
  function automatic search_t next_enabled(input logic [MAX_STAGES-1:0] bypass,
                                           input logic [4:0]            from);
    search_t r;
    r = '0;
    // Descending scan: the last hit written is the lowest qualifying index.
    for (int i = MAX_STAGES - 1; i >= 0; i--) begin
      if (!bypass[i] && (5'(i) >= from)) begin
        r.valid = 1'b1;
        r.idx   = 4'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/chain_seq_timer.sv
// chain_seq_timer
//   WAIT-state timeout counter for the chain sequencer.
//   Ports:
//     clk, reset   clock, asynchronous active-low reset
//     clear        zero the counter (stage launch)
//     enable       count one WAIT cycle; saturates at all ones
//     limit        timeout length in WAIT cycles; 0 disables the timeout
//     expired      high in the WAIT cycle that is the limit-th one
module chain_seq_timer #(
  parameter int TMO_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [TMO_W-1:0] limit,
  output logic             expired
);

  logic [TMO_W-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + TMO_W'(1);
    end
  end

  // count holds the number of WAIT cycles already spent, so the limit-th
  // WAIT cycle is the one where count == limit-1.
  assign expired = (limit != '0) && (count == (limit - TMO_W'(1)));

endmodule

// File: rtl/chain_sequencer.sv
// chain_sequencer
//   N-stage start/done walker for the TX/RX processing chain. Launches each
//   non-bypassed stage in ascending order, waits for its done, strobes the
//   stage's output register capture, then moves on. Moves no data itself.
//
//   Handshake: a frame request is taken on a clock edge where start=1,
//   in_ready=1 and abort=0; in_ready is high exactly when the sequencer is
//   idle, and start seen while in_ready=0 is dropped, not queued.
//
//   Ports:
//     clk, reset      clock, asynchronous active-low reset
//     start, abort    frame request / synchronous abort to idle
//     in_ready, busy  idle / frame in progress
//     done            one-cycle pulse at frame completion
//     error           sticky timeout flag, cleared by the next accepted start
//     err_stage       index of the stage that timed out
//     bypass_mask     stages to skip, latched at start acceptance
//     timeout_limit   WAIT cycles before timeout, 0 disables
//     stage_start     one-hot launch pulse per stage
//     stage_done      level done from each stage
//     stage_capture   one-hot load strobe for a stage's output register
//     frame_count     completed frames   (CHAIN_SEQ_STATS_EN, else 0)
//     error_count     timed-out frames   (CHAIN_SEQ_STATS_EN, else 0)
//     state_dbg       current FSM state (state_t encoding)
//
//   Optional: define CHAIN_SEQ_STATS_EN to build the saturating counters.
module chain_sequencer
  import chain_seq_pkg::*;
#(
  parameter int NUM_STAGES = 6,
  parameter int TMO_W      = 16,
  parameter int IDX_W      = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  output logic                  in_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [IDX_W-1:0]      err_stage,
  input  logic [NUM_STAGES-1:0] bypass_mask,
  input  logic [TMO_W-1:0]      timeout_limit,
  output logic [NUM_STAGES-1:0] stage_start,
  input  logic [NUM_STAGES-1:0] stage_done,
  output logic [NUM_STAGES-1:0] stage_capture,
  output logic [STAT_W-1:0]     frame_count,
  output logic [STAT_W-1:0]     error_count,
  output logic [2:0]            state_dbg
);

  state_t                state, state_d;
  logic [NUM_STAGES-1:0] mask_q;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [MAX_STAGES-1:0] mask_pad_in, mask_pad_q;
  logic [NUM_STAGES-1:0] idx_oh;
  search_t               first_hit, next_hit;
  logic                  done_sel;
  logic                  accept, enter_err;
  logic                  tmr_clear, tmr_en, tmr_expired;

  // Unused upper search positions read as bypassed.
  always_comb begin
    mask_pad_in                 = '1;
    mask_pad_in[NUM_STAGES-1:0] = bypass_mask;
    mask_pad_q                  = '1;
    mask_pad_q[NUM_STAGES-1:0]  = mask_q;
  end

  assign first_hit = next_enabled(mask_pad_in, 5'd0);
  assign next_hit  = next_enabled(mask_pad_q, 5'(idx_q) + 5'd1);
  assign idx_oh    = NUM_STAGES'(1) << idx_q;
  // Only the active stage's done matters; the others may be stale or noisy.
  assign done_sel  = stage_done[idx_q];

  chain_seq_timer #(.TMO_W(TMO_W)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (tmr_clear),
    .enable  (tmr_en),
    .limit   (timeout_limit),
    .expired (tmr_expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      idx_q     <= '0;
      mask_q    <= '0;
      error     <= 1'b0;
      err_stage <= '0;
    end else begin
      state <= state_d;
      idx_q <= idx_d;
      if (accept) begin
        mask_q    <= bypass_mask;
        error     <= 1'b0;
        err_stage <= '0;
      end else if (enter_err) begin
        error     <= 1'b1;
        err_stage <= idx_q;
      end
    end
  end

  always_comb begin
    state_d       = state;
    idx_d         = idx_q;
    accept        = 1'b0;
    enter_err     = 1'b0;
    tmr_clear     = 1'b0;
    tmr_en        = 1'b0;
    stage_start   = '0;
    stage_capture = '0;
    done          = 1'b0;
    case (state)
      S_IDLE: begin
        // abort in IDLE has no effect other than blocking acceptance.
        if (start && !abort) begin
          accept = 1'b1;
          if (first_hit.valid) begin
            idx_d   = IDX_W'(first_hit.idx);
            state_d = S_LAUNCH;
          end else begin
            state_d = S_FINISH;
          end
        end
      end
      S_LAUNCH: begin
        stage_start = idx_oh;
        tmr_clear   = 1'b1;
        state_d     = S_WAIT;
      end
      S_WAIT: begin
        // done beats a timeout that expires in the same cycle.
        if (done_sel) begin
          state_d = S_ADVANCE;
        end else begin
          tmr_en = 1'b1;
          if (tmr_expired) begin
            enter_err = 1'b1;
            state_d   = S_ERROR;
          end
        end
      end
      S_ADVANCE: begin
        stage_capture = idx_oh;
        if (next_hit.valid) begin
          idx_d   = IDX_W'(next_hit.idx);
          state_d = S_LAUNCH;
        end else begin
          state_d = S_FINISH;
        end
      end
      S_FINISH: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      S_ERROR: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // abort overrides everything outside IDLE and silences the strobes.
    if (abort && (state != S_IDLE)) begin
      state_d       = S_IDLE;
      idx_d         = idx_q;
      enter_err     = 1'b0;
      tmr_clear     = 1'b0;
      tmr_en        = 1'b0;
      stage_start   = '0;
      stage_capture = '0;
      done          = 1'b0;
    end
  end

  assign in_ready  = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

`ifdef CHAIN_SEQ_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_count <= '0;
      error_count <= '0;
    end else begin
      if (done && (frame_count != '1)) frame_count <= frame_count + STAT_W'(1);
      if (enter_err && (error_count != '1)) error_count <= error_count + STAT_W'(1);
    end
  end
`else
  assign frame_count = '0;
  assign error_count = '0;
`endif

endmodule
